// File: rtl/sat_dot_accum.sv
// sat_dot_accum
// Sequential saturating dot-product engine:
//   out_sum = sat16(bias + sum over N beats of sat16((w*v) >>> FRAC))
// Every intermediate addition is clamped to the signed 16-bit range. There is
// no latch at the rail, so later beats can move the accumulator back off it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin an operation (sampled only in IDLE)
//   bias       initial accumulator value, captured with start
//   in_valid   w/v pair valid
//   in_ready   engine accepts a w/v pair this cycle (ACCUM)
//   w, v       signed Q(15-FRAC).FRAC operands
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   out_sum    accumulator value (meaningful while out_valid=1)
//   sat_flag   sticky: some clamp occurred since the last accepted start
//   busy       high in ACCUM or DONE
//
// All outputs come either from flops or from a decode of the state register
// only. There is no combinational path from in_valid/out_ready to the outputs.

module sat_dot_accum #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] w,
  input  logic [15:0] v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        sat_flag,
  output logic        busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Clamp a 32-bit signed value to 16 bits; bit 16 of the result flags a clamp.
  function automatic logic [16:0] clamp_from32(input logic signed [31:0] x);
    logic [16:0] r;
    if (x > 32'sd32767) begin
      r = {1'b1, 16'h7FFF};
    end else if (x < -32'sd32768) begin
      r = {1'b1, 16'h8000};
    end else begin
      r = {1'b0, x[15:0]};
    end
    return r;
  endfunction

  // Clamp a 17-bit signed sum to 16 bits; bit 16 of the result flags a clamp.
  function automatic logic [16:0] clamp_from17(input logic signed [16:0] x);
    logic [16:0] r;
    if (x > 17'sd32767) begin
      r = {1'b1, 16'h7FFF};
    end else if (x < -17'sd32768) begin
      r = {1'b1, 16'h8000};
    end else begin
      r = {1'b0, x[15:0]};
    end
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sat_q, sat_d;

  logic signed [31:0] w_ext_s, v_ext_s, prod_s, shifted_s;
  logic [16:0]        term_sat_s;
  logic signed [16:0] sum_s;
  logic [16:0]        acc_sat_s;
  logic               beat_s;

  // Datapath: product, arithmetic shift (floor), term clamp, accumulator clamp.
  always_comb begin
    w_ext_s    = $signed({{16{w[15]}}, w});
    v_ext_s    = $signed({{16{v[15]}}, v});
    // |w*v| <= 2^30, so the 32-bit product is exact.
    prod_s     = w_ext_s * v_ext_s;
    shifted_s  = prod_s >>> FRAC;
    term_sat_s = clamp_from32(shifted_s);
    sum_s      = $signed({acc_q[15], acc_q}) + $signed({term_sat_s[15], term_sat_s[15:0]});
    acc_sat_s  = clamp_from17(sum_s);
  end

  // Next-state logic for the IDLE/ACCUM/DONE sequencer and its registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    beat_s  = in_valid & (state_q == ACCUM);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = bias;
          count_d = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          acc_d = acc_sat_s[15:0];
          sat_d = sat_q | term_sat_s[16] | acc_sat_s[16];
          if (count_q == LAST_BEAT) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        // Result is held until the consumer takes it; start and w/v are ignored.
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = 16'h0000;
        count_d = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) | (state_q == DONE);
  assign out_sum   = acc_q;
  assign sat_flag  = sat_q;

endmodule
